matrix_shift_rx: RTL and testbench
==================================

Name: matrix_shift_rx

Overview:
- Receive-side model of the 8x8 RGB matrix shift interface: deserialises the shift-clock, latch and data lines driven by the matrix driver and rebuilds the displayed rows.
- Rebuilt rows are held in an 8-row store, readable over the same 32-bit, 3-bit-address, 4-bit-select Wishbone slave format the matrix framebuffer uses. A loopback read of this store must match what was written to the framebuffer.
- Used for on-board loopback checking on spare gp pins and as the bench-side receiver.

Parameters:
- SHIFT_BITS, 32, number of bits per latched frame (8 row-select + 24 colour).
- CNT_W, 16, width of the latched-frame counter.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- i_matrix_clk  input  1  external shift clock, asynchronous to clk
- i_matrix_latch  input  1  external output-latch strobe, asynchronous
- i_matrix_mosi  input  1  external serial data, asynchronous
- i_wb_cyc  input  1  Wishbone cycle
- i_wb_stb  input  1  Wishbone strobe
- i_wb_we  input  1  Wishbone write enable
- i_wb_addr  input  3  row index
- i_wb_sel  input  4  byte select
- i_wb_wdata  input  32  write data (control only)
- o_wb_ack  output  1  Wishbone acknowledge
- o_wb_stall  output  1  Wishbone stall, tied 0
- o_wb_rdata  output  32  read data
- o_frame_count  output  CNT_W  latched frames received, wraps
- o_err_length  output  1  sticky: a latch arrived with bit count != SHIFT_BITS
- o_err_onehot  output  1  sticky: row-select byte was not exactly one-hot
- o_latch_pulse  output  1  one-cycle pulse on each latch processed

Behaviour:
- Reset values: all outputs 0, row store all 0, shift register 0, bit count 0. Reset asserted mid-frame discards partial bits.
- Synchronisers: each external input passes through a 2-FF synchroniser plus one history FF. A rising edge is sync2=1 and hist=0.
  - Total edge-to-action latency is 3 clk cycles.
  - Each external level must hold at least 2 clk cycles; faster toggles are out of contract.
- Shift: on each synchronised i_matrix_clk rising edge:
  - shreg <= {shreg[SHIFT_BITS-2:0], mosi_sync}, MSB first.
  - bitcnt increments, saturating at 2*SHIFT_BITS-1.
- Frame word after SHIFT_BITS shifts is {row[7:0], R[7:0], G[7:0], B[7:0]}, with row at bits 31:24. All bits are active-high.
- Latch: on a synchronised i_matrix_latch rising edge:
  - If bitcnt != SHIFT_BITS, set o_err_length.
  - If row has exactly one bit set at position r, write row store entry r. Otherwise set o_err_onehot and write nothing.
  - Row-store entry format: for pixel c in 0..7, bits [4c+2:4c] = {R[c],G[c],B[c]} and bit 4c+3 = 0.
  - A length error does not block the write; the last SHIFT_BITS bits shifted are used.
  - bitcnt <= 0, o_frame_count increments (wraps at 2^CNT_W), o_latch_pulse = 1 for one cycle.
- Shift and latch edges in the same cycle: the shift is applied first. The latch decodes the word including the new bit and compares bitcnt+1, then bitcnt <= 0.
- Wishbone:
  - o_wb_stall is always 0. Every i_wb_cyc&i_wb_stb cycle gets o_wb_ack=1 exactly one cycle later, and ack is single-cycle per strobe.
  - Back-to-back strobes give back-to-back acks.
  - Read: o_wb_rdata = row store[i_wb_addr], registered with the ack. If a latch writes the same row in the request cycle, the old value is returned.
  - o_wb_rdata holds its last value when no read is acked.
  - Write: row store is not writable. If i_wb_sel[0]=1 and i_wb_wdata[0]=1, both sticky errors clear on the ack cycle.
  - If an error is set in the same cycle as a clear, the error wins.
  - If i_wb_sel[0]=1 and i_wb_wdata[1]=1, o_frame_count clears.
  - A write is acked regardless of sel.

Test Plan:
- Reset, then read addr 0..7 -> each acked 1 cycle after stb, rdata 0; counts and flags 0.
- Shift 32 bits 0x04_FF_00_0F (row 2, R all, B pixels 0-3), then latch -> addr 2 reads 0x44445555; frame_count=1; no errors; o_latch_pulse exactly one cycle.
- Shift 31 bits, then latch -> o_err_length=1 and stays 1. Then write wdata=1, sel=4'b0001 -> flag 0 after ack.
- Shift row byte 0x06 (two bits set) plus 24 bits, then latch -> o_err_onehot=1; all rows unchanged.
- Latch edge synchronised in the same cycle as the 32nd clk edge -> frame accepted, no length error, correct row written.
- Assert reset midway through 16 shifted bits, release, then send a full valid frame for row 7 -> only row 7 non-zero and frame_count=1.

Source files
------------

// File: rtl/matrix_shift_rx.sv
// rtl/matrix_shift_rx.sv - receive side of the 8x8 RGB matrix shift link with Wishbone row readback
module matrix_shift_rx #(
   parameter int SHIFT_BITS = 32,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_matrix_clk,
   input  logic             i_matrix_latch,
   input  logic             i_matrix_mosi,
   input  logic             i_wb_cyc,
   input  logic             i_wb_stb,
   input  logic             i_wb_we,
   input  logic [2:0]       i_wb_addr,
   input  logic [3:0]       i_wb_sel,
   input  logic [31:0]      i_wb_wdata,
   output logic             o_wb_ack,
   output logic             o_wb_stall,
   output logic [31:0]      o_wb_rdata,
   output logic [CNT_W-1:0] o_frame_count,
   output logic             o_err_length,
   output logic             o_err_onehot,
   output logic             o_latch_pulse
);

   localparam int BW = $clog2(2 * SHIFT_BITS);
   localparam logic [BW-1:0] BITCNT_MAX = BW'(2 * SHIFT_BITS - 1);
   localparam logic [BW-1:0] BITCNT_FULL = BW'(SHIFT_BITS);

   // [0]=first sync stage, [1]=second sync stage, [2]=history for edge detect
   logic [2:0]            sclk_q, slatch_q;
   logic [1:0]            smosi_q;
   logic [SHIFT_BITS-1:0] shreg_q, shreg_d;
   logic [BW-1:0]         bitcnt_q, bitcnt_d;
   logic [31:0]           store_q [8];
   logic                  ack_q;
   logic [31:0]           rdata_q, rdata_d;
   logic [CNT_W-1:0]      frame_cnt_q, frame_cnt_d;
   logic                  err_len_q, err_len_d;
   logic                  err_oh_q, err_oh_d;
   logic                  pulse_q;

   logic        clk_rise, latch_rise;
   logic [31:0] frame;
   logic [7:0]  row_sel;
   logic [2:0]  row_idx;
   logic        row_onehot;
   logic [31:0] row_entry;
   logic        latch_wr, err_len_set, err_oh_set;
   logic        wb_req, wb_wr_ctl, err_clr, cnt_clr;
   logic        wb_unused;

   assign clk_rise   = sclk_q[1] & ~sclk_q[2];
   assign latch_rise = slatch_q[1] & ~slatch_q[2];
   assign wb_unused  = ^{i_wb_sel[3:1], i_wb_wdata[31:2]};

   // Bring the asynchronous matrix lines into the clk domain
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sclk_q   <= '0;
         slatch_q <= '0;
         smosi_q  <= '0;
      end else begin
         sclk_q   <= {sclk_q[1:0], i_matrix_clk};
         slatch_q <= {slatch_q[1:0], i_matrix_latch};
         smosi_q  <= {smosi_q[0], i_matrix_mosi};
      end
   end

   // Shift first, then let a coincident latch decode the word including the new bit
   always_comb begin
      shreg_d     = shreg_q;
      bitcnt_d    = bitcnt_q;
      latch_wr    = 1'b0;
      err_len_set = 1'b0;
      err_oh_set  = 1'b0;
      if (clk_rise) begin
         shreg_d  = {shreg_q[SHIFT_BITS-2:0], smosi_q[1]};
         bitcnt_d = (bitcnt_q == BITCNT_MAX) ? bitcnt_q : bitcnt_q + BW'(1);
      end
      if (latch_rise) begin
         err_len_set = (bitcnt_d != BITCNT_FULL);
         latch_wr    = row_onehot;
         err_oh_set  = ~row_onehot;
         bitcnt_d    = '0;
      end
   end

   assign frame      = shreg_d[31:0];
   assign row_sel    = frame[31:24];
   assign row_onehot = (row_sel != 8'd0) && ((row_sel & (row_sel - 8'd1)) == 8'd0);

   // Turn the row byte into an index and repack colours as 4-bit {0,R,G,B} pixels
   always_comb begin
      row_idx   = 3'd0;
      row_entry = '0;
      for (int r = 0; r < 8; r++) begin
         if (row_sel[r]) row_idx = 3'(r);
      end
      for (int c = 0; c < 8; c++) begin
         row_entry[4*c +: 4] = {1'b0, frame[16+c], frame[8+c], frame[c]};
      end
   end

   // Wishbone control decode, sticky flags (set beats clear) and frame counter
   always_comb begin
      wb_req    = i_wb_cyc & i_wb_stb;
      wb_wr_ctl = wb_req & i_wb_we & i_wb_sel[0];
      err_clr   = wb_wr_ctl & i_wb_wdata[0];
      cnt_clr   = wb_wr_ctl & i_wb_wdata[1];
      err_len_d = err_len_set | (err_len_q & ~err_clr);
      err_oh_d  = err_oh_set | (err_oh_q & ~err_clr);
      frame_cnt_d = frame_cnt_q;
      if (latch_rise) begin
         frame_cnt_d = cnt_clr ? CNT_W'(1) : frame_cnt_q + CNT_W'(1);
      end else if (cnt_clr) begin
         frame_cnt_d = '0;
      end
      rdata_d = (wb_req & ~i_wb_we) ? store_q[i_wb_addr] : rdata_q;
   end

   // State registers; reads sample the store before a same-cycle latch write lands
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shreg_q     <= '0;
         bitcnt_q    <= '0;
         ack_q       <= 1'b0;
         rdata_q     <= '0;
         frame_cnt_q <= '0;
         err_len_q   <= 1'b0;
         err_oh_q    <= 1'b0;
         pulse_q     <= 1'b0;
         for (int r = 0; r < 8; r++) store_q[r] <= '0;
      end else begin
         shreg_q     <= shreg_d;
         bitcnt_q    <= bitcnt_d;
         ack_q       <= wb_req;
         rdata_q     <= rdata_d;
         frame_cnt_q <= frame_cnt_d;
         err_len_q   <= err_len_d;
         err_oh_q    <= err_oh_d;
         pulse_q     <= latch_rise;
         if (latch_wr) store_q[row_idx] <= row_entry;
      end
   end

   assign o_wb_ack      = ack_q;
   assign o_wb_stall    = 1'b0;
   assign o_wb_rdata    = rdata_q;
   assign o_frame_count = frame_cnt_q;
   assign o_err_length  = err_len_q;
   assign o_err_onehot  = err_oh_q;
   assign o_latch_pulse = pulse_q;

endmodule

// File: tb/tb_matrix_shift_rx.sv
// tb/tb_matrix_shift_rx.sv - directed scoreboard bench for matrix_shift_rx
module tb_matrix_shift_rx;

   logic        clk, reset;
   logic        mclk, mlatch, mmosi;
   logic        wb_cyc, wb_stb, wb_we;
   logic [2:0]  wb_addr;
   logic [3:0]  wb_sel;
   logic [31:0] wb_wdata;
   logic        wb_ack, wb_stall;
   logic [31:0] wb_rdata;
   logic [15:0] frame_count;
   logic        err_length, err_onehot, latch_pulse;

   int passed = 0;
   int total  = 0;
   int pulse_total = 0;
   int pulse_base;

   logic [31:0] m_sh;
   logic [31:0] exp_rows [8];
   logic [31:0] exp_q [$];

   matrix_shift_rx #(.SHIFT_BITS(32), .CNT_W(16)) dut (
      .clk(clk), .reset(reset),
      .i_matrix_clk(mclk), .i_matrix_latch(mlatch), .i_matrix_mosi(mmosi),
      .i_wb_cyc(wb_cyc), .i_wb_stb(wb_stb), .i_wb_we(wb_we),
      .i_wb_addr(wb_addr), .i_wb_sel(wb_sel), .i_wb_wdata(wb_wdata),
      .o_wb_ack(wb_ack), .o_wb_stall(wb_stall), .o_wb_rdata(wb_rdata),
      .o_frame_count(frame_count), .o_err_length(err_length),
      .o_err_onehot(err_onehot), .o_latch_pulse(latch_pulse)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(negedge clk) if (latch_pulse) pulse_total++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   function automatic logic [31:0] encode(input logic [31:0] w);
      logic [31:0] e;
      e = '0;
      for (int c = 0; c < 8; c++) e[4*c +: 4] = {1'b0, w[16+c], w[8+c], w[c]};
      return e;
   endfunction

   task automatic model_latch();
      logic [7:0] row;
      int hits;
      row  = m_sh[31:24];
      hits = 0;
      for (int r = 0; r < 8; r++) if (row[r]) hits++;
      if (hits == 1) begin
         for (int r = 0; r < 8; r++) if (row[r]) exp_rows[r] = encode(m_sh);
      end
   endtask

   task automatic shift_bit(input logic b);
      @(negedge clk) mmosi = b;
      repeat (2) @(negedge clk);
      mclk = 1'b1;
      repeat (3) @(negedge clk);
      mclk = 1'b0;
      m_sh = {m_sh[30:0], b};
   endtask

   task automatic send_bits(input logic [31:0] w, input int n);
      for (int i = n - 1; i >= 0; i--) shift_bit(w[i]);
   endtask

   task automatic do_latch();
      @(negedge clk) mlatch = 1'b1;
      repeat (3) @(negedge clk);
      mlatch = 1'b0;
      repeat (6) @(negedge clk);
      model_latch();
   endtask

   // 31 ordinary bits, then the 32nd shift edge and the latch edge together
   task automatic send_frame_coincident(input logic [31:0] w);
      send_bits(w >> 1, 31);
      @(negedge clk) mmosi = w[0];
      repeat (2) @(negedge clk);
      mclk   = 1'b1;
      mlatch = 1'b1;
      repeat (3) @(negedge clk);
      mclk   = 1'b0;
      mlatch = 1'b0;
      m_sh = {m_sh[30:0], w[0]};
      repeat (6) @(negedge clk);
      model_latch();
   endtask

   task automatic pop_check(input string tag);
      logic [31:0] e;
      chk({tag, "_ack"}, {31'd0, wb_ack}, 32'd1);
      if (exp_q.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
         e = exp_q.pop_front();
         chk({tag, "_rdata"}, wb_rdata, e);
      end
   endtask

   // back-to-back reads of all rows, one pop per ack
   task automatic read_all(input string tag);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (i > 0) pop_check(tag);
         wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_addr = 3'(i);
         exp_q.push_back(exp_rows[i]);
      end
      @(negedge clk);
      pop_check(tag);
      wb_cyc = 1'b0; wb_stb = 1'b0;
      @(negedge clk);
      chk({tag, "_ack_single"}, {31'd0, wb_ack}, 32'd0);
   endtask

   task automatic read_one(input string tag, input logic [2:0] a);
      @(negedge clk);
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_addr = a;
      exp_q.push_back(exp_rows[a]);
      @(negedge clk);
      pop_check(tag);
      wb_cyc = 1'b0; wb_stb = 1'b0;
      @(negedge clk);
      chk({tag, "_ack_single"}, {31'd0, wb_ack}, 32'd0);
   endtask

   // leaves the caller on the ack cycle
   task automatic wb_write(input string tag, input logic [31:0] d, input logic [3:0] s);
      @(negedge clk);
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_wdata = d; wb_sel = s;
      @(negedge clk);
      chk({tag, "_ack"}, {31'd0, wb_ack}, 32'd1);
      wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      mclk = 1'b0; mlatch = 1'b0; mmosi = 1'b0;
      wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
      wb_addr = '0; wb_sel = '0; wb_wdata = '0;
      m_sh = '0;
      for (int r = 0; r < 8; r++) exp_rows[r] = '0;
      repeat (3) @(negedge clk);
      chk("rst_count", {16'd0, frame_count}, 32'd0);
      chk("rst_errlen", {31'd0, err_length}, 32'd0);
      chk("rst_erroh", {31'd0, err_onehot}, 32'd0);
      chk("rst_pulse", {31'd0, latch_pulse}, 32'd0);
      chk("rst_ack", {31'd0, wb_ack}, 32'd0);
      chk("rst_rdata", wb_rdata, 32'd0);
      reset = 1'b0;
      read_all("rst_rows");
      chk("stall", {31'd0, wb_stall}, 32'd0);

      // valid frame for row 2
      pulse_base = pulse_total;
      send_bits(32'h04FF000F, 32);
      do_latch();
      chk("f1_pulse_cycles", 32'(pulse_total - pulse_base), 32'd1);
      chk("f1_count", {16'd0, frame_count}, 32'd1);
      chk("f1_errlen", {31'd0, err_length}, 32'd0);
      chk("f1_erroh", {31'd0, err_onehot}, 32'd0);
      chk("f1_model_row2", exp_rows[2], 32'h44445555);
      read_one("f1_row2", 3'd2);

      // short frame: 31 bits, length error is sticky, row still written
      send_bits(32'h00AA55C3, 31);
      do_latch();
      chk("short_errlen", {31'd0, err_length}, 32'd1);
      chk("short_erroh", {31'd0, err_onehot}, 32'd0);
      chk("short_count", {16'd0, frame_count}, 32'd2);
      repeat (20) @(negedge clk);
      chk("short_errlen_sticky", {31'd0, err_length}, 32'd1);
      read_one("short_row7", 3'd7);
      wb_write("clr1", 32'd1, 4'b0001);
      chk("clr1_errlen", {31'd0, err_length}, 32'd0);
      chk("clr1_count_kept", {16'd0, frame_count}, 32'd2);

      // two row-select bits: no write anywhere
      send_bits(32'h06123456, 32);
      do_latch();
      chk("oh_erroh", {31'd0, err_onehot}, 32'd1);
      chk("oh_errlen", {31'd0, err_length}, 32'd0);
      chk("oh_count", {16'd0, frame_count}, 32'd3);
      read_all("oh_rows");
      wb_write("clr2", 32'd3, 4'b0001);
      chk("clr2_erroh", {31'd0, err_onehot}, 32'd0);
      chk("clr2_count", {16'd0, frame_count}, 32'd0);

      // 32nd shift edge and latch edge in the same cycle
      pulse_base = pulse_total;
      send_frame_coincident(32'h1000FF00);
      chk("co_errlen", {31'd0, err_length}, 32'd0);
      chk("co_erroh", {31'd0, err_onehot}, 32'd0);
      chk("co_count", {16'd0, frame_count}, 32'd1);
      chk("co_pulse_cycles", 32'(pulse_total - pulse_base), 32'd1);
      chk("co_model_row4", exp_rows[4], 32'h22222222);
      read_one("co_row4", 3'd4);

      // reset mid-frame discards partial bits and clears the store
      send_bits(32'h0000BEEF, 16);
      @(negedge clk) reset = 1'b1;
      repeat (2) @(negedge clk);
      chk("mid_rst_count", {16'd0, frame_count}, 32'd0);
      reset = 1'b0;
      m_sh = '0;
      for (int r = 0; r < 8; r++) exp_rows[r] = '0;
      send_bits(32'h800FF03C, 32);
      do_latch();
      chk("mid_count", {16'd0, frame_count}, 32'd1);
      chk("mid_errlen", {31'd0, err_length}, 32'd0);
      chk("mid_erroh", {31'd0, err_onehot}, 32'd0);
      read_all("mid_rows");

      chk("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
